// File: rtl/event_encoder_if.sv
// Handshake/bus bundle for the 8-to-3 event encoder: raw event lines and
// capture enable toward the encoder, indexed events back to the consumer.
interface event_encoder_if;
  logic       a, b, c, d, e, f, g, h;
  logic       oe;
  logic       ready;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] pending;
  logic       ovf;

  // Encoder side: samples lines, presents indices.
  modport slave (
    input  a, b, c, d, e, f, g, h, oe, ready,
    output sel, valid, pending, ovf
  );

  // Producer/consumer side: drives lines, accepts indices.
  modport master (
    output a, b, c, d, e, f, g, h, oe, ready,
    input  sel, valid, pending, ovf
  );
endinterface

// File: rtl/event_encoder.sv
// Registered 8-to-3 event encoder. Rising edges on a..h are latched as
// pending events and presented one at a time on sel (lowest index first)
// under a valid/ready handshake.
module event_encoder (
  input  logic            clk,
  input  logic            rst_n,
  event_encoder_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Bit gi of an index is set for the lines whose number has bit gi set.
  localparam logic [23:0] IDX_MASKS = {8'hF0, 8'hCC, 8'hAA};

  state_t     state_reg, state_next;
  logic [7:0] in_vec;
  logic [7:0] prev_reg;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] rise, cap, clr, lowest;
  logic [2:0] sel_reg, sel_next, low_idx;
  logic       ovf_reg, ovf_next;
  logic       free, load;

  assign in_vec = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  assign rise   = in_vec & ~prev_reg;
  assign cap    = rise & {8{bus.oe}};

  // Isolate the lowest set pending bit (two's-complement trick).
  assign lowest = pending_reg & (~pending_reg + 8'd1);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_enc
      assign low_idx[gi] = |(lowest & IDX_MASKS[gi*8 +: 8]);
    end
  endgenerate

  // The stage can take a new event when empty or when the held one transfers.
  assign free = (state_reg == IDLE) | bus.ready;
  assign load = free & (|pending_reg);
  assign clr  = load ? lowest : 8'h00;

  // Set wins over clear: a fresh edge on the line being presented re-arms it.
  assign pending_next = (pending_reg & ~clr) | cap;
  assign ovf_next     = |(cap & pending_reg & ~clr);
  assign sel_next     = load ? low_idx : sel_reg;

  // State register plus datapath registers; prev resets high so lines
  // already asserted at reset release do not register as edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      prev_reg    <= 8'hFF;
      pending_reg <= 8'h00;
      sel_reg     <= 3'd0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= in_vec;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      ovf_reg     <= ovf_next;
    end
  end

  // Next state: hold while stalled, otherwise follow pending occupancy.
  always_comb begin
    state_next = state_reg;
    if (free) begin
      state_next = load ? HOLD : IDLE;
    end
  end

  // Outputs: valid is decoded from the state, the rest are registered.
  always_comb begin
    bus.valid   = (state_reg == HOLD);
    bus.sel     = sel_reg;
    bus.pending = pending_reg;
    bus.ovf     = ovf_reg;
  end

endmodule

// File: tb/tb_event_encoder.sv
// Directed self-checking bench for event_encoder.
module tb_event_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  event_encoder_if bus ();

  event_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lines();
    bus.a = 0; bus.b = 0; bus.c = 0; bus.d = 0;
    bus.e = 0; bus.f = 0; bus.g = 0; bus.h = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_lines();
    bus.oe = 1'b1;
    bus.ready = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.valid !== 1'b0 || bus.sel !== 3'd0 || bus.pending !== 8'h00 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b sel=%0d pending=%h ovf=%b, required 0/0/00/0",
               bus.valid, bus.sel, bus.pending, bus.ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL reset_release: valid=%b pending=%h, required 0/00", bus.valid, bus.pending);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus.oe = 1'b1;
    bus.ready = 1'b1;
    bus.d = 1'b1;
    tick();
    bus.d = 1'b0;
    checks++;
    if (bus.pending !== 8'h08 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pending: pending=%h valid=%b, required 08/0", bus.pending, bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.sel !== 3'd3 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL single_present: valid=%b sel=%0d pending=%h, required 1/3/00",
               bus.valid, bus.sel, bus.pending);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL single_drain: valid=%b pending=%h, required 0/00", bus.valid, bus.pending);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_sel [3];
    logic [7:0] exp_pend [3];
    exp_sel[0] = 3'd0; exp_sel[1] = 3'd2; exp_sel[2] = 3'd7;
    exp_pend[0] = 8'h84; exp_pend[1] = 8'h80; exp_pend[2] = 8'h00;
    bus.ready = 1'b1;
    bus.a = 1; bus.c = 1; bus.h = 1;
    tick();
    clear_lines();
    checks++;
    if (bus.pending !== 8'h85) begin
      failures++;
      $display("FAIL b2b_pending: pending=%h, required 85", bus.pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.sel !== exp_sel[i] || bus.pending !== exp_pend[i]) begin
        failures++;
        $display("FAIL b2b_seq%0d: valid=%b sel=%0d pending=%h, required 1/%0d/%h",
                 i, bus.valid, bus.sel, bus.pending, exp_sel[i], exp_pend[i]);
      end
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: valid=%b, required 0", bus.valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    bus.ready = 1'b0;
    bus.f = 1'b1;
    tick();
    bus.f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.sel !== 3'd5) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b sel=%0d, required 1/5", i, bus.valid, bus.sel);
      end
    end
    bus.ready = 1'b1;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL bp_transfer: valid=%b pending=%h, required 0/00", bus.valid, bus.pending);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_nodup: valid=%b, required 0", bus.valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_overflow();
    bus.ready = 1'b0;
    bus.b = 1; bus.c = 1;
    tick();
    clear_lines();
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.sel !== 3'd1 || bus.pending !== 8'h04 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_setup: valid=%b sel=%0d pending=%h ovf=%b, required 1/1/04/0",
               bus.valid, bus.sel, bus.pending, bus.ovf);
    end
    bus.c = 1'b1;
    tick();
    bus.c = 1'b0;
    checks++;
    if (bus.ovf !== 1'b1 || bus.pending !== 8'h04) begin
      failures++;
      $display("FAIL ovf_pulse: ovf=%b pending=%h, required 1/04", bus.ovf, bus.pending);
    end
    tick();
    checks++;
    if (bus.ovf !== 1'b0 || bus.pending !== 8'h04 || bus.sel !== 3'd1) begin
      failures++;
      $display("FAIL ovf_oneshot: ovf=%b pending=%h sel=%0d, required 0/04/1",
               bus.ovf, bus.pending, bus.sel);
    end
    // Line 2 rises on the same edge it gets loaded into sel.
    bus.ready = 1'b1;
    bus.c = 1'b1;
    tick();
    bus.c = 1'b0;
    checks++;
    if (bus.sel !== 3'd2 || bus.valid !== 1'b1 || bus.pending !== 8'h04 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL set_over_clear: sel=%0d valid=%b pending=%h ovf=%b, required 2/1/04/0",
               bus.sel, bus.valid, bus.pending, bus.ovf);
    end
    tick();
    checks++;
    if (bus.sel !== 3'd2 || bus.valid !== 1'b1 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL reissue: sel=%0d valid=%b pending=%h, required 2/1/00",
               bus.sel, bus.valid, bus.pending);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain: valid=%b, required 0", bus.valid);
    end
    $display("test_overflow done");
  endtask

  task automatic test_oe();
    bus.ready = 1'b1;
    bus.oe = 1'b0;
    bus.b = 1; bus.g = 1;
    tick();
    clear_lines();
    checks++;
    if (bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL oe_block: pending=%h, required 00", bus.pending);
    end
    tick();
    checks++;
    if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL oe_block2: pending=%h valid=%b, required 00/0", bus.pending, bus.valid);
    end
    bus.oe = 1'b1;
    bus.ready = 1'b0;
    bus.a = 1; bus.e = 1;
    tick();
    clear_lines();
    tick();
    checks++;
    if (bus.sel !== 3'd0 || bus.valid !== 1'b1 || bus.pending !== 8'h10) begin
      failures++;
      $display("FAIL oe_setup: sel=%0d valid=%b pending=%h, required 0/1/10",
               bus.sel, bus.valid, bus.pending);
    end
    bus.oe = 1'b0;
    bus.ready = 1'b1;
    tick();
    checks++;
    if (bus.sel !== 3'd4 || bus.valid !== 1'b1 || bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL oe_drain: sel=%0d valid=%b pending=%h, required 4/1/00",
               bus.sel, bus.valid, bus.pending);
    end
    tick();
    bus.oe = 1'b1;
    $display("test_oe done");
  endtask

  task automatic test_reset_behaviour();
    bus.e = 1'b1;
    do_reset();
    tick();
    checks++;
    if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL level_high_reset: pending=%h valid=%b, required 00/0", bus.pending, bus.valid);
    end
    bus.e = 1'b0;
    bus.ready = 1'b0;
    bus.d = 1'b1;
    tick();
    bus.d = 1'b0;
    bus.b = 1'b1;
    tick();
    bus.b = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.sel !== 3'd3 || bus.pending !== 8'h02) begin
      failures++;
      $display("FAIL midrst_setup: valid=%b sel=%0d pending=%h, required 1/3/02",
               bus.valid, bus.sel, bus.pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00 || bus.sel !== 3'd0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b pending=%h sel=%0d ovf=%b, required 0/00/0/0",
               bus.valid, bus.pending, bus.sel, bus.ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset_behaviour done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear_lines();
    bus.oe = 1'b1;
    bus.ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_oe();
    test_reset_behaviour();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
# event_encoder

Registered 8-to-3 event encoder. It is the capture-side counterpart of the 3-to-8 `decoder`: eight single-bit lines `a`..`h` go in, and each rising edge on a line is latched as a pending event. Pending events are presented one at a time as a 3-bit index `sel`, lowest index first, under a valid/ready handshake. Sits between raw strobe lines and any consumer that drives a `decoder` or indexes by `sel`.

## Interface
- No parameters; width fixed at 8 lines / 3-bit index.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  in  1 each  event lines, bit 0 (`a`) to bit 7 (`h`); synchronous to `clk`.
- `oe`  in  1  capture enable; 0 = rising edges ignored (not latched).
- `ready`  in  1  consumer accepts the current `sel`.
- `sel`  out  3  index of the presented event, 0..7.
- `valid`  out  1  `sel` holds a live event.
- `pending`  out  8  latched, not-yet-presented events, bit i = line i.
- `ovf`  out  1  one-cycle pulse: a rising edge hit a line whose pending bit was already set.

## Operation
- Internal `prev[7:0]` samples `{h,g,f,e,d,c,b,a}` every cycle.
- `rise = in & ~prev`; `cap = rise & {8{oe}}`.
- Pending update per edge: `pending <= (pending & ~clr) | cap`. Set wins over clear on the same bit in the same cycle.
- `ovf <= |(cap & pending & ~clr)`.
- Output stage has two states:
  - IDLE: `valid`=0.
  - HOLD: `valid`=1, `sel` stable.
- The stage is free when in IDLE, or in HOLD with `ready`=1.
- When the stage is free and `pending != 0`:
  - `sel` <= index of the lowest set bit of `pending` (value before this edge's update).
  - `clr` = that one-hot bit.
  - Next state is HOLD.
- When the stage is free and `pending == 0`: next state is IDLE and `sel` holds its last value.
- In HOLD with `ready`=0: `sel`, `valid` and the stage are unchanged.
- `ready` is ignored in IDLE.
- `oe`=0 only blocks capture. Pending events keep draining.
- An event already presented on `sel` is no longer in `pending`. A new edge on that line re-sets the pending bit without raising `ovf`.

## Timing
- Reset (async assert, sync-safe release):
  - `prev` = 8'hFF, so lines already high at release do not fire.
  - `pending` = 0, `sel` = 0, `valid` = 0, `ovf` = 0, state IDLE.
- Latency: a line goes high before edge k, with `prev`=0 and `oe`=1. The pending bit sets at edge k. With the stage free, `valid`/`sel` present it after edge k+1, i.e. 2 cycles from input to `valid`.
- Throughput: one event per cycle while `ready`=1. Back-to-back pending bits produce consecutive `sel` values with `valid` held high.
- Handshake: transfer happens on an edge where `valid`=1 and `ready`=1. `sel` must not change while `valid`=1 and `ready`=0.
- Priority: fixed, lowest index first. Line 0 can starve higher lines if it re-fires every cycle; this is accepted.
- Level-high lines fire once. Another edge needs the line to go low for at least one cycle.
- Reset mid-operation clears all pending and presented events immediately. No `ovf` is raised.

## Test plan
- Reset, then single event:
  - Stimulus: `oe`=1, `ready`=1, pulse `d` high for 1 cycle at edge 5.
  - Required: `pending`=8'h08 after edge 5; `valid`=1, `sel`=3 after edge 6; `valid`=0 after edge 7; `pending`=0.
- Simultaneous edges:
  - Stimulus: `a`,`c`,`h` rise together, `ready`=1.
  - Required: `sel` = 0, 2, 7 on three consecutive cycles with `valid` continuously 1, then `valid`=0.
- Backpressure:
  - Stimulus: event on `f`, `ready`=0 for 4 cycles.
  - Required: `sel`=5, `valid`=1 held stable across all 4 cycles; one transfer when `ready`=1; no duplicate.
- Overflow and set-over-clear:
  - Stimulus: hold `ready`=0 with `sel`=1 presented, `pending`=8'h04; pulse `c` again.
  - Required: `ovf`=1 for exactly one cycle; `pending` stays 8'h04.
  - Stimulus: a rising edge on line 2 on the same edge that line 2 is loaded into `sel`.
  - Required: `pending[2]`=1 afterwards; `ovf`=0.
- Capture enable:
  - Stimulus: `oe`=0, pulse `b` and `g`.
  - Required: `pending` stays 0.
  - Stimulus: with `pending`=8'h10, set `oe`=0.
  - Required: `sel`=4 is still presented.
- Reset behaviour:
  - Stimulus: hold `e` high through reset release.
  - Required: no event.
  - Stimulus: assert `rst_n`=0 mid-stream with `valid`=1.
  - Required: `valid`, `pending`, `sel`, `ovf` go to 0 without waiting for `clk`.
